// File: rtl/uart_rx_param.sv
// uart_rx_param
// Oversampled UART receiver with mid-bit sampling and a valid/ack output
// holding register. The line is synchronised through two flops; a start bit
// that is high again at its midpoint is treated as a glitch and ignored.
// Each frame reports parity, framing, overrun and break conditions.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active high
//   rx     in   serial line, idle high, asynchronous to clk
//   ack    in   consumer accepts the held word (only meaningful while valid)
//   data   out  received word, bit0 = first data bit on the line
//   valid  out  data/error hold a completed frame
//   error  out  [0] parity, [1] framing, [2] overrun, [3] break
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic [3:0]           error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = 4;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // synchroniser
  logic rx_meta_q, rx_s_q;

  // frame receive state
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   zero_q, zero_d;     // every data/parity bit so far was 0
  logic                   stop0_q, stop0_d;   // first stop bit sampled as 0

  // output holding register
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic [3:0]             error_q, error_d;

  // per-frame results, meaningful only when frame_done
  logic frame_done;
  logic fr_par, fr_frm, fr_brk;
  logic tick;
  logic par_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      zero_q    <= 1'b0;
      stop0_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      zero_q    <= zero_d;
      stop0_q   <= stop0_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  // receive FSM: every decision happens when the baud counter reaches 0
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    zero_d     = zero_q;
    stop0_d    = stop0_q;
    frame_done = 1'b0;
    fr_par     = 1'b0;
    fr_frm     = 1'b0;
    fr_brk     = 1'b0;
    tick       = (cnt_q == '0);
    par_x      = (^shift_q) ^ rx_s_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) begin
          // half a bit to land on the middle of the start bit
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end

      S_START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = CNT_FULL;
            bit_d     = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            zero_d    = 1'b1;
            stop0_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (tick) begin
          // LSB arrives first, so shift in from the top
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~rx_s_q;
          cnt_d   = CNT_FULL;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_PARITY: begin
        if (tick) begin
          par_err_d = (PARITY_MODE == 1) ? par_x : ~par_x;
          zero_d    = zero_q & ~rx_s_q;
          cnt_d     = CNT_FULL;
          bit_d     = '0;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (tick) begin
          frm_err_d = frm_err_q | ~rx_s_q;
          if (bit_q == '0) stop0_d = ~rx_s_q;
          if (bit_q == LAST_STOP) begin
            // frame completes at the middle of the last stop bit so the
            // next start edge can be caught right away
            frame_done = 1'b1;
            fr_par     = par_err_q;
            fr_frm     = frm_err_q | ~rx_s_q;
            fr_brk     = zero_q & ((bit_q == '0) ? ~rx_s_q : stop0_q);
            state_d    = S_IDLE;
            cnt_d      = '0;
            bit_d      = '0;
          end else begin
            bit_d = bit_q + 1'b1;
            cnt_d = CNT_FULL;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // holding register: a completed frame wins over a plain ack on the same
  // edge; if the old word is still unacknowledged the new one is dropped
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    error_d = error_q;
    if (frame_done) begin
      if (!valid_q || ack) begin
        data_d  = shift_q;
        error_d = {fr_brk, 1'b0, fr_frm, fr_par};
        valid_d = 1'b1;
      end else begin
        error_d[2] = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
      error_d = '0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
// Three receiver configurations (8N1, 8E1 and 7O2 at 8 clocks per bit) share
// clock and reset. Frames are described as events: each send computes the
// completion cycle, expected word and flags; a cycle model of the holding
// register then predicts valid/data/error, compared every falling edge.
module tb_uart_rx_param;

  localparam int CPB_A[3] = '{16, 16, 8};
  localparam int DB_A[3]  = '{8, 8, 7};
  localparam int PM_A[3]  = '{0, 1, 2};
  localparam int SB_A[3]  = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx, ack, v;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [3:0] err0, err1, err2;
  logic [8:0] dut_d[3];
  logic [3:0] dut_e[3];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .ack(ack[0]), .data(d0), .valid(v[0]), .error(err0));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .ack(ack[1]), .data(d1), .valid(v[1]), .error(err1));
  uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .ack(ack[2]), .data(d2), .valid(v[2]), .error(err2));

  assign dut_d[0] = {1'b0, d0};
  assign dut_d[1] = {1'b0, d1};
  assign dut_d[2] = {2'b0, d2};
  assign dut_e[0] = err0;
  assign dut_e[1] = err1;
  assign dut_e[2] = err2;

  // frame events and output model
  int         cyc = 0;
  int         pend_c[3]  = '{-1, -1, -1};
  logic [8:0] pend_d[3];
  logic [3:0] pend_e[3];
  int         ack_at[3]  = '{-1, -1, -1};
  int         last_e0[3] = '{0, 0, 0};
  logic       m_v[3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] m_d[3] = '{9'd0, 9'd0, 9'd0};
  logic [3:0] m_e[3] = '{4'd0, 4'd0, 4'd0};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_v[i] = 1'b0;
        m_d[i] = '0;
        m_e[i] = '0;
      end else if (pend_c[i] == cyc) begin
        if (!m_v[i] || ack[i]) begin
          m_d[i] = pend_d[i];
          m_e[i] = pend_e[i];
          m_v[i] = 1'b1;
        end else begin
          m_e[i][2] = 1'b1;
        end
      end else if (m_v[i] && ack[i]) begin
        m_v[i] = 1'b0;
        m_e[i] = '0;
      end
    end
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] ack_dir;
  bit         ack_rand;
  int         ack_pct;
  logic [2:0] pv = '0;
  int         rise_cyc[3] = '{0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock step: compare against the model, then drive ack for the next edge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({v[i], dut_d[i], dut_e[i]} !== {m_v[i], m_d[i], m_e[i]}) begin
        n_fail++;
        $display("FAIL model_u%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b (cycle %0d)",
                 i, v[i], dut_d[i], dut_e[i], m_v[i], m_d[i], m_e[i], cyc);
      end
      if (v[i] && !pv[i]) rise_cyc[i] = cyc;
      pv[i] = v[i];
    end
    for (int i = 0; i < 3; i++)
      ack[i] = ack_rand ? ($urandom_range(0, 99) < ack_pct)
                        : (ack_dir[i] | (ack_at[i] == cyc + 1));
  endtask

  task automatic ack_pulse(input int i);
    ack_dir[i] = 1'b1;
    tick();
    ack_dir[i] = 1'b0;
    tick();
    chk($sformatf("ack_clears_u%0d", i), int'(v[i]), 0);
  endtask

  // send one frame on instance i; pforce<0 gives correct parity
  task automatic send(input int i, input logic [8:0] d, input int pforce,
                      input logic [1:0] stops, input bit ack_c);
    int cpb, db, pm, sb, lat, ones, gap;
    logic [8:0] dm;
    logic pc, p;
    bit perr, frm, brk;
    cpb = CPB_A[i]; db = DB_A[i]; pm = PM_A[i]; sb = SB_A[i];
    dm   = d & ((9'd1 << db) - 9'd1);
    ones = $countones(dm);
    pc   = (pm == 1) ? ones[0] : ~ones[0];
    p    = (pforce < 0) ? pc : pforce[0];
    perr = (pm != 0) && (p != pc);
    frm  = (stops[0] == 1'b0) || (sb == 2 && stops[1] == 1'b0);
    brk  = (dm == 0) && (pm == 0 || p == 1'b0) && (stops[0] == 1'b0);
    lat  = 2 + cpb / 2 + cpb * (db + ((pm != 0) ? 1 : 0) + sb);
    last_e0[i] = cyc + 1;
    pend_d[i]  = dm;
    pend_e[i]  = {brk, 1'b0, frm, perr};
    pend_c[i]  = cyc + 1 + lat;
    if (ack_c) ack_at[i] = pend_c[i];
    rx[i] = 1'b0;
    repeat (cpb) tick();
    for (int k = 0; k < db; k++) begin
      rx[i] = dm[k];
      repeat (cpb) tick();
    end
    if (pm != 0) begin
      rx[i] = p;
      repeat (cpb) tick();
    end
    for (int s = 0; s < sb; s++) begin
      rx[i] = stops[s];
      repeat (cpb) tick();
    end
    rx[i] = 1'b1;
    // a low last stop bit looks like a start edge; give it time to be rejected
    gap = (stops[sb-1] == 1'b0) ? 3 * cpb : int'($urandom_range(0, 6));
    repeat (gap) tick();
  endtask

  initial begin
    rst = 1'b1; rx = '1; ack = '0; ack_dir = '0; ack_rand = 1'b0; ack_pct = 0;
    repeat (3) tick();
    chk("reset_valid", int'(v), 0);
    chk("reset_data0", int'(d0), 0);
    chk("reset_error0", int'(err0), 0);
    rst = 1'b0;
    repeat (4) tick();

    // 8N1 0xA5: latency and content
    send(0, 9'hA5, -1, 2'b11, 1'b0);
    chk("latency_8n1", rise_cyc[0] - last_e0[0], 154);
    chk("a5_valid", int'(v[0]), 1);
    chk("a5_data", int'(d0), 'hA5);
    chk("a5_error", int'(err0), 0);
    ack_pulse(0);

    // short start glitch, then a clean frame
    rx[0] = 1'b0;
    repeat (4) tick();
    rx[0] = 1'b1;
    repeat (40) tick();
    chk("glitch_no_valid", int'(v[0]), 0);
    send(0, 9'h3C, -1, 2'b11, 1'b0);
    chk("3c_data", int'(d0), 'h3C);
    chk("3c_error", int'(err0), 0);
    ack_pulse(0);

    // even parity
    send(1, 9'h07, 0, 2'b11, 1'b0);
    chk("par_bad_data", int'(d1), 'h07);
    chk("par_bad_error", int'(err1), 'b0001);
    ack_pulse(1);
    send(1, 9'h07, 1, 2'b11, 1'b0);
    chk("par_ok_error", int'(err1), 0);
    chk("par_ok_valid", int'(v[1]), 1);
    ack_pulse(1);

    // framing and break
    send(0, 9'h55, -1, 2'b00, 1'b0);
    chk("frm_data", int'(d0), 'h55);
    chk("frm_error", int'(err0), 'b0010);
    ack_pulse(0);
    send(0, 9'h00, -1, 2'b00, 1'b0);
    chk("brk_data", int'(d0), 0);
    chk("brk_error", int'(err0), 'b1010);
    ack_pulse(0);

    // overrun, then completion on the same edge as ack
    send(0, 9'h11, -1, 2'b11, 1'b0);
    send(0, 9'h22, -1, 2'b11, 1'b0);
    chk("ovr_data", int'(d0), 'h11);
    chk("ovr_error", int'(err0), 'b0100);
    ack_pulse(0);
    send(0, 9'h11, -1, 2'b11, 1'b0);
    send(0, 9'h22, -1, 2'b11, 1'b1);
    chk("ack_on_c_data", int'(d0), 'h22);
    chk("ack_on_c_error", int'(err0), 0);
    chk("ack_on_c_valid", int'(v[0]), 1);
    ack_pulse(0);

    // reset in the middle of a frame with a word still held
    send(0, 9'h5A, -1, 2'b11, 1'b0);
    rx[0] = 1'b0;
    repeat (16) tick();
    rx[0] = 1'b1;
    repeat (16) tick();
    rx[0] = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", int'(v[0]), 0);
    chk("rst_data", int'(d0), 0);
    chk("rst_error", int'(err0), 0);
    rx[0] = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    repeat (5) tick();
    send(0, 9'h42, -1, 2'b11, 1'b0);
    chk("post_rst_data", int'(d0), 'h42);
    chk("post_rst_error", int'(err0), 0);
    ack_pulse(0);

    // 7O2 at 8 clocks per bit
    send(2, 9'h55, -1, 2'b11, 1'b0);
    chk("latency_7o2", rise_cyc[2] - last_e0[2], 86);
    chk("7o2_data", int'(d2), 'h55);
    chk("7o2_error", int'(err2), 0);
    ack_pulse(2);

    // random frames with random acknowledgement
    ack_rand = 1'b1;
    for (int n = 0; n < 45; n++) begin
      int       inst, pf;
      logic [1:0] st;
      inst    = int'($urandom_range(0, 2));
      pf      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      st      = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      ack_pct = int'($urandom_range(0, 4));
      send(inst, 9'($urandom), pf, st, 1'b0);
    end
    ack_rand = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
